// File: rtl/cpu_if_arb_pkg.sv
// Shared types and constants for the CPU register-bus round-robin arbiter.
package cpu_if_arb_pkg;

  localparam int ADDR_WIDTH = 30;
  localparam int DATA_WIDTH = 32;

  // Read data returned to a requester whose access was completed by timeout.
  localparam logic [DATA_WIDTH-1:0] ERROR_READ_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FLUSH = 2'd3
  } cpu_if_arb_state_e;

endpackage

// File: rtl/cpu_if_rr_picker.sv
// Combinational rotate-priority picker: returns the first set request bit at
// or after the pointer, wrapping modulo NUM_REQ.
module cpu_if_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan from the farthest offset down to offset 0 so the closest request wins.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_w;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_w       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (req[idx_w]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

endmodule

// File: rtl/cpu_if_arbiter.sv
// Round-robin arbiter sharing one downstream CPU register bus between
// NUM_REQ requesters. Optional access timeout: CPU_IF_ARB_TIMEOUT_EN.
//
// Handshake: a requester raises req_read/req_write (write wins if both) and
// holds it, with address/data stable, until its one-cycle req_access_complete
// bit; it drops the request on the following edge. Downstream sees a
// single-cycle m_read/m_write pulse and answers with a single-cycle
// m_access_complete; only one downstream access is ever outstanding.
module cpu_if_arbiter
  import cpu_if_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_REQ-1:0]                    req_read,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_write_data,
  output logic [DATA_WIDTH-1:0]                 req_read_data,
  output logic [NUM_REQ-1:0]                    req_access_complete,
  output logic [NUM_REQ-1:0]                    req_error,
  output logic                                  m_read,
  output logic                                  m_write,
  output logic [ADDR_WIDTH-1:0]                 m_address,
  output logic [DATA_WIDTH-1:0]                 m_write_data,
  input  logic [DATA_WIDTH-1:0]                 m_read_data,
  input  logic                                  m_access_complete,
  output cpu_if_arb_state_e                     dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("cpu_if_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cpu_if_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  cpu_if_arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [PTR_W-1:0]         grant_q, grant_d;
  logic                     is_wr_q, is_wr_d;
  logic                     m_read_q, m_read_d;
  logic                     m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0]    m_address_q, m_address_d;
  logic [DATA_WIDTH-1:0]    m_write_data_q, m_write_data_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [NUM_REQ-1:0]       cmpl_q, cmpl_d;

  logic [PTR_W-1:0]         pick_idx;
  logic                     pick_valid;

`ifdef CPU_IF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]       err_q, err_d;
`endif

  cpu_if_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req         (req_read | req_write),
    .ptr         (ptr_q),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    is_wr_d        = is_wr_q;
    m_read_d       = 1'b0;
    m_write_d      = 1'b0;
    m_address_d    = m_address_q;
    m_write_data_d = m_write_data_q;
    rdata_d        = rdata_q;
    cmpl_d         = '0;
`ifdef CPU_IF_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_d          = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d        = pick_idx;
          is_wr_d        = req_write[pick_idx];
          m_write_d      = req_write[pick_idx];
          m_read_d       = ~req_write[pick_idx];
          m_address_d    = req_address[pick_idx];
          m_write_data_d = req_write_data[pick_idx];
          ptr_d          = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d        = ST_WAIT;
`ifdef CPU_IF_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (m_access_complete) begin
          if (!is_wr_q) rdata_d = m_read_data;
          cmpl_d[grant_q] = 1'b1;
          state_d         = ST_DONE;
        end
`ifdef CPU_IF_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d         = ERROR_READ_DATA;
          cmpl_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          cnt_d           = '0;
          state_d         = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        // Requests are ignored here so the completing requester can drop.
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
`ifdef CPU_IF_ARB_TIMEOUT_EN
        // Absorb the late downstream completion, or give up after a timeout.
        if (m_access_complete || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register FSM state and every output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      grant_q        <= '0;
      is_wr_q        <= 1'b0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_address_q    <= '0;
      m_write_data_q <= '0;
      rdata_q        <= '0;
      cmpl_q         <= '0;
`ifdef CPU_IF_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_q        <= grant_d;
      is_wr_q        <= is_wr_d;
      m_read_q       <= m_read_d;
      m_write_q      <= m_write_d;
      m_address_q    <= m_address_d;
      m_write_data_q <= m_write_data_d;
      rdata_q        <= rdata_d;
      cmpl_q         <= cmpl_d;
`ifdef CPU_IF_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign m_read              = m_read_q;
  assign m_write             = m_write_q;
  assign m_address           = m_address_q;
  assign m_write_data        = m_write_data_q;
  assign req_read_data       = rdata_q;
  assign req_access_complete = cmpl_q;
  assign dbg_state           = state_q;
`ifdef CPU_IF_ARB_TIMEOUT_EN
  assign req_error           = err_q;
`else
  assign req_error           = '0;
`endif

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Bench for cpu_if_arbiter: vector table of single transactions, then
// round-robin, reset-during-access and (with CPU_IF_ARB_TIMEOUT_EN) timeout
// sequences.
module tb_cpu_if_arbiter;
  import cpu_if_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic                               clk = 1'b0;
  logic                               reset_n = 1'b0;
  logic [N-1:0]                       req_read = '0;
  logic [N-1:0]                       req_write = '0;
  logic [N-1:0][ADDR_WIDTH-1:0]       req_address = '0;
  logic [N-1:0][DATA_WIDTH-1:0]       req_write_data = '0;
  logic [DATA_WIDTH-1:0]              req_read_data;
  logic [N-1:0]                       req_access_complete;
  logic [N-1:0]                       req_error;
  logic                               m_read;
  logic                               m_write;
  logic [ADDR_WIDTH-1:0]              m_address;
  logic [DATA_WIDTH-1:0]              m_write_data;
  logic [DATA_WIDTH-1:0]              m_read_data = '0;
  logic                               m_access_complete = 1'b0;
  cpu_if_arb_state_e                  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  // Clock.
  always #5 clk = ~clk;

  cpu_if_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_read            (req_read),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .req_read_data       (req_read_data),
    .req_access_complete (req_access_complete),
    .req_error           (req_error),
    .m_read              (m_read),
    .m_write             (m_write),
    .m_address           (m_address),
    .m_write_data        (m_write_data),
    .m_read_data         (m_read_data),
    .m_access_complete   (m_access_complete),
    .dbg_state           (dbg_state)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    int          idx;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] ds_rdata;
    int          lat;
    logic        exp_rd;
    logic        exp_wr;
    logic [3:0]  exp_cmpl;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait (bounded) for a downstream pulse; returns at the negedge it is seen.
  task automatic wait_pulse(output bit found);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m_read || m_write) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Called at the negedge where the pulse is visible: checks the pulse is one
  // cycle, answers after lat cycles and checks the completion cycle.
  task automatic complete_and_check(input int lat, input logic [31:0] ds,
                                    input logic [3:0] exp_cmpl, input logic [31:0] exp_rdata);
    bit quiet_bad;
    @(negedge clk);
    check("pulse_one_cycle", {62'd0, m_read, m_write}, 64'd0);
    quiet_bad = 1'b0;
    if (|req_access_complete) quiet_bad = 1'b1;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      if (m_read || m_write || (|req_access_complete)) quiet_bad = 1'b1;
    end
    check("quiet_while_waiting", {63'd0, quiet_bad}, 64'd0);
    m_access_complete = 1'b1;
    m_read_data       = ds;
    @(negedge clk);
    m_access_complete = 1'b0;
    check("complete_onehot", req_access_complete, exp_cmpl);
    check("read_data", req_read_data, exp_rdata);
    check("error_clear", req_error, 4'b0000);
    check("state_done", dbg_state, ST_DONE);
  endtask

  task automatic run_vec(input vec_t v);
    bit found;
    req_read[v.idx]       = v.rd;
    req_write[v.idx]      = v.wr;
    req_address[v.idx]    = v.addr;
    req_write_data[v.idx] = v.wdata;
    wait_pulse(found);
    check("pulse_seen", {63'd0, found}, 64'd1);
    check("m_read", {63'd0, m_read}, {63'd0, v.exp_rd});
    check("m_write", {63'd0, m_write}, {63'd0, v.exp_wr});
    check("m_address", m_address, v.addr);
    check("m_write_data", m_write_data, v.wdata);
    complete_and_check(v.lat, v.ds_rdata, v.exp_cmpl, v.exp_rdata);
    req_read  = '0;
    req_write = '0;
    @(negedge clk);
    check("complete_cleared", req_access_complete, 4'b0000);
  endtask

  initial begin
    bit   found;
    int   exp_g;
    vec_t fin;

    vecs[0] = '{1'b0, 1'b1, 2, 30'h10,       32'hA5A5_A5A5, 32'hFFFF_0000, 4, 1'b0, 1'b1, 4'b0100, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 1, 30'h20,       32'h0000_0000, 32'h1234_5678, 2, 1'b1, 1'b0, 4'b0010, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 3, 30'h3FFF_FFFF, 32'hCAFE_F00D, 32'h0BAD_F00D, 1, 1'b0, 1'b1, 4'b1000, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 0, 30'h0,        32'h0000_0000, 32'hFFFF_FFFF, 3, 1'b1, 1'b0, 4'b0001, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 1'b1, 1, 30'h155,      32'h0000_0000, 32'h0000_1111, 1, 1'b0, 1'b1, 4'b0010, 32'hFFFF_FFFF};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_m_read", {63'd0, m_read}, 64'd0);
    check("rst_m_write", {63'd0, m_write}, 64'd0);
    check("rst_m_address", m_address, 30'h0);
    check("rst_complete", req_access_complete, 4'b0000);
    check("rst_read_data", req_read_data, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_pulse", {62'd0, m_read, m_write}, 64'd0);
    check("idle_state", dbg_state, ST_IDLE);

    // Table of single transactions.
    for (int v = 0; v < NV; v++) run_vec(vecs[v]);

    // Round robin from a fresh reset: all four request, twice around.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_address[i]    = 30'h100 + 30'(i);
      req_write_data[i] = 32'(i);
    end
    req_write = 4'b1111;
    for (int g = 0; g < 2 * N; g++) begin
      exp_g = g % N;
      wait_pulse(found);
      check("rr_pulse_seen", {63'd0, found}, 64'd1);
      check("rr_grant_addr", m_address, 30'h100 + 30'(exp_g));
      complete_and_check(1, 32'h0, 4'(1 << exp_g), 32'h0);
      req_write[exp_g] = 1'b0;
      @(negedge clk);
      check("rr_complete_cleared", req_access_complete, 4'b0000);
      req_write[exp_g] = 1'b1;
    end
    req_write = '0;
    repeat (2) @(negedge clk);

    // Prime rdata with a read so the reset clearing it is visible.
    fin = '{1'b1, 1'b0, 0, 30'h9, 32'h0, 32'h7777_0001, 1, 1'b1, 1'b0, 4'b0001, 32'h7777_0001};
    run_vec(fin);

    // Reset during WAIT; a late completion afterwards must be ignored.
    req_read[2]    = 1'b1;
    req_address[2] = 30'h77;
    wait_pulse(found);
    check("rw_pulse_seen", {63'd0, found}, 64'd1);
    @(negedge clk);
    check("rw_in_wait", dbg_state, ST_WAIT);
    reset_n = 1'b0;
    #1;
    check("rw_state_idle", dbg_state, ST_IDLE);
    check("rw_address_zero", m_address, 30'h0);
    check("rw_read_data_zero", req_read_data, 32'h0);
    req_read = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m_access_complete = 1'b1;
    @(negedge clk);
    m_access_complete = 1'b0;
    check("rw_late_ignored", req_access_complete, 4'b0000);
    check("rw_state_after", dbg_state, ST_IDLE);
    // Pointer restarted at 0: requester 1 beats requester 3.
    req_write[1] = 1'b1; req_address[1] = 30'h11; req_write_data[1] = 32'h1;
    req_write[3] = 1'b1; req_address[3] = 30'h33; req_write_data[3] = 32'h3;
    wait_pulse(found);
    check("rw_next_seen", {63'd0, found}, 64'd1);
    check("rw_next_grant_addr", m_address, 30'h11);
    complete_and_check(2, 32'h0, 4'b0010, 32'h0);
    req_write = '0;
    repeat (2) @(negedge clk);

`ifdef CPU_IF_ARB_TIMEOUT_EN
    // No downstream completion: forced completion after TO WAIT cycles.
    begin
      bit early;
      req_read[0]    = 1'b1;
      req_address[0] = 30'h5;
      wait_pulse(found);
      check("to_pulse_seen", {63'd0, found}, 64'd1);
      early = 1'b0;
      for (int i = 0; i < TO - 1; i++) begin
        @(negedge clk);
        if (|req_access_complete) early = 1'b1;
      end
      check("to_not_early", {63'd0, early}, 64'd0);
      @(negedge clk);
      check("to_complete", req_access_complete, 4'b0001);
      check("to_error", req_error, 4'b0001);
      check("to_read_data", req_read_data, 32'hDEAD_BEEF);
      check("to_state_flush", dbg_state, ST_FLUSH);
      req_read = '0;
      @(negedge clk);
      m_access_complete = 1'b1;
      @(negedge clk);
      m_access_complete = 1'b0;
      check("to_late_absorbed", req_access_complete, 4'b0000);
      check("to_state_idle", dbg_state, ST_IDLE);
    end
`endif

    // Normal service afterwards.
    fin = '{1'b1, 1'b0, 2, 30'h2A, 32'h0, 32'h55AA_55AA, 2, 1'b1, 1'b0, 4'b0100, 32'h55AA_55AA};
    run_vec(fin);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_if_arbiter.md
# cpu_if_arbiter

Round-robin arbiter that shares one downstream CPU register bus between NUM_REQ requesters on the same clock. Each requester holds a level read or write request until it gets a one-cycle completion. The arbiter issues the single-cycle read/write pulse the bus expects and returns read data and the completion to the granted requester only. It sits on the high-clock side, in front of the bus crossing or a register bank, so several local masters can share one bus.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters, ≥2
- TIMEOUT_CYCLES, 1024, WAIT cycles before forced completion (used only with the timeout feature)

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- req_read  in  NUM_REQ  per-requester read request, level
- req_write  in  NUM_REQ  per-requester write request, level
- req_address  in  NUM_REQ×30  per-requester word address [31:2]
- req_write_data  in  NUM_REQ×32  per-requester write data
- req_read_data  out  32  shared read-data return, valid with completion
- req_access_complete  out  NUM_REQ  one-hot, one-cycle completion pulse
- req_error  out  NUM_REQ  one-cycle timeout flag, coincident with completion
- m_read  out  1  downstream read pulse
- m_write  out  1  downstream write pulse
- m_address  out  30  downstream address [31:2]
- m_write_data  out  32  downstream write data
- m_read_data  in  32  downstream read data
- m_access_complete  in  1  downstream completion pulse

## Operation
- All outputs are registered. On reset every output is 0, the FSM is IDLE and the RR pointer is 0.
- Request rules:
  - A requester asserts req_read or req_write and holds it, with address and data stable, until it sees its req_access_complete bit.
  - It deasserts on the following edge.
- If a requester asserts read and write together, the write is performed and the read is ignored.
- FSM states: IDLE, WAIT, DONE, FLUSH.
- IDLE with any request pending:
  - Grant the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the grant index, m_address and m_write_data.
  - Pulse m_read or m_write for one cycle.
  - Set the pointer to grant+1 mod NUM_REQ.
  - Go to WAIT.
- IDLE with no request: hold all outputs.
- WAIT, on m_access_complete:
  - Register m_read_data into req_read_data (updated for reads only; writes leave it unchanged).
  - Pulse req_access_complete[grant].
  - Go to DONE.
- DONE: one cycle that ignores all requests, so the completing requester can drop its level. Then go to IDLE.
- m_access_complete sampled in IDLE or DONE is discarded.
- Only one downstream access is ever outstanding.

## Timing
- Request sampled high at edge 0 → m_read/m_write high during cycle 0 → low at edge 1.
- m_access_complete sampled at edge k → req_access_complete and req_read_data valid during cycle k.
- Minimum grant-to-grant spacing is 3 cycles plus the downstream latency.
- The pointer moves only on a grant. A requester that waits is served within NUM_REQ−1 other grants.
- Asynchronous reset mid-access returns the FSM to IDLE immediately. A late completion that follows is discarded.

## Configuration
- CPU_IF_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT. Once TIMEOUT_CYCLES cycles pass without m_access_complete, the arbiter completes the access itself.
  - On that forced completion: req_read_data = 32'hDEAD_BEEF, req_access_complete[grant] and req_error[grant] pulse together, and the FSM goes to FLUSH.
  - FLUSH stays until m_access_complete arrives (discarded) or another TIMEOUT_CYCLES pass, then goes to IDLE.
- CPU_IF_ARB_TIMEOUT_EN undefined: WAIT waits indefinitely, FLUSH is unreachable and req_error is constant 0.

## Structure
- Package cpu_if_arb_pkg holds:
  - the state enum
  - ERROR_READ_DATA = 32'hDEAD_BEEF
  - ADDR_WIDTH = 30 and DATA_WIDTH = 32
- Sub-module cpu_if_rr_picker is a combinational rotate-priority picker: requests and pointer in; grant index and valid out.

## Test plan
- Single write on requester 2 (address 0x10, data 0xA5A5A5A5), downstream completes 4 cycles after m_write → one m_write pulse carrying those values; req_access_complete = 4'b0100 for one cycle.
- All four requesters request at once from reset → grants in order 0, 1, 2, 3. Repeating with all still requesting → order 0, 1, 2, 3 again.
- Read on requester 1, downstream returns 0x12345678 → req_read_data = 0x12345678 in the completion cycle; requester 0's bit stays 0.
- Read and write both high on requester 3 → only m_write pulses.
- With the macro and TIMEOUT_CYCLES = 8, no downstream completion → after 8 WAIT cycles: completion + req_error on the granted bit, read data 0xDEADBEEF. A late m_access_complete is absorbed in FLUSH.
- reset_n low during WAIT, then a completion pulse after release → no req_access_complete; next request served normally from pointer 0.
